mem_refill_ctrl: RTL and testbench

// Miss sequencer and arbiter between the I-cache and D-cache for the single external memory port.

---
 rtl/mem_refill_ctrl_pkg.sv | 24 ++
 rtl/mem_refill_ctrl_if.sv | 28 ++
 rtl/mem_refill_ctrl_beat_counter.sv | 38 +++
 rtl/mem_refill_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_refill_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_refill_ctrl_pkg.sv
// Shared types and helpers for the cache refill controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_BEAT,
    RD_REQ,
    RD_BEAT,
    DONE
  } refill_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  // Number of byte-offset bits inside one cache line.
  function automatic int unsigned line_off_bits(input int unsigned block_words,
                                                input int unsigned data_width);
    return $clog2(block_words * data_width / 8);
  endfunction

endpackage

// File: rtl/mem_refill_ctrl_if.sv
// Request/beat handshake between the refill controller and the memory bus adapter.
interface mem_refill_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 64
) ();

  logic                  o_mem_req_valid;
  logic                  i_mem_req_ready;
  logic [ADDR_WIDTH-1:0] o_mem_req_addr;
  logic                  o_mem_req_we;
  logic                  i_mem_beat_valid;

  modport master (
    output o_mem_req_valid,
    output o_mem_req_addr,
    output o_mem_req_we,
    input  i_mem_req_ready,
    input  i_mem_beat_valid
  );

  modport slave (
    input  o_mem_req_valid,
    input  o_mem_req_addr,
    input  o_mem_req_we,
    output i_mem_req_ready,
    output i_mem_beat_valid
  );

endinterface

// File: rtl/mem_refill_ctrl_beat_counter.sv
// Beat counter for one line transfer; wraps naturally at a power-of-two line size.
module beat_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_arstn,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == '1);

endmodule

// File: rtl/mem_refill_ctrl.sv
// Miss sequencer/arbiter between I-cache and D-cache for the single memory port.
// D-cache has fixed priority; dirty victims are written back before the refill.
module mem_refill_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic                           i_clk,
  input  logic                           i_arstn,
  input  logic                           i_icache_miss,
  input  logic [ADDR_WIDTH-1:0]          i_icache_addr,
  input  logic                           i_dcache_miss,
  input  logic [ADDR_WIDTH-1:0]          i_dcache_addr,
  input  logic                           i_dcache_dirty,
  input  logic [ADDR_WIDTH-1:0]          i_dcache_wb_addr,
  mem_refill_ctrl_if.master              mem,
  output logic [$clog2(BLOCK_WORDS)-1:0] o_beat_idx,
  output logic                           o_icache_fill_we,
  output logic                           o_dcache_fill_we,
  output logic                           o_dcache_wb_rd,
  output logic                           o_icache_done,
  output logic                           o_dcache_done,
  output logic                           o_stall_fetch,
  output logic                           o_stall_mem
);

  localparam int unsigned IDX_W    = $clog2(BLOCK_WORDS);
  localparam int unsigned OFF_BITS = line_off_bits(BLOCK_WORDS, DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));

  refill_state_t         state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  req_valid_q, req_we_q, wb_rd_q, i_done_q, d_done_q;
  logic                  cnt_clear, cnt_inc, cnt_last;
  logic [IDX_W-1:0]      cnt;
  logic                  busy;

  beat_counter #(.WIDTH(IDX_W)) u_beat_counter (
    .i_clk   (i_clk),
    .i_arstn (i_arstn),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .count   (cnt),
    .last    (cnt_last)
  );

  // Next-state, owner/address latching and beat-counter control.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_addr_d = req_addr_q;
    rd_addr_d  = rd_addr_q;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (i_dcache_miss) begin
          owner_d   = OWN_D;
          rd_addr_d = i_dcache_addr & LINE_MASK;
          if (i_dcache_dirty) begin
            state_d    = WB_REQ;
            req_addr_d = i_dcache_wb_addr & LINE_MASK;
          end else begin
            state_d    = RD_REQ;
            req_addr_d = i_dcache_addr & LINE_MASK;
          end
        end else if (i_icache_miss) begin
          owner_d    = OWN_I;
          state_d    = RD_REQ;
          req_addr_d = i_icache_addr & LINE_MASK;
        end
      end
      WB_REQ: begin
        if (mem.i_mem_req_ready) begin
          state_d   = WB_BEAT;
          cnt_clear = 1'b1;
        end
      end
      WB_BEAT: begin
        cnt_inc = mem.i_mem_beat_valid;
        if (mem.i_mem_beat_valid && cnt_last) begin
          state_d    = RD_REQ;
          req_addr_d = rd_addr_q;
        end
      end
      RD_REQ: begin
        if (mem.i_mem_req_ready) begin
          state_d   = RD_BEAT;
          cnt_clear = 1'b1;
        end
      end
      RD_BEAT: begin
        cnt_inc = mem.i_mem_beat_valid;
        if (mem.i_mem_beat_valid && cnt_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; registered outputs are decoded from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      req_addr_q  <= '0;
      rd_addr_q   <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      wb_rd_q     <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      req_addr_q  <= req_addr_d;
      rd_addr_q   <= rd_addr_d;
      req_valid_q <= (state_d == WB_REQ) || (state_d == RD_REQ);
      req_we_q    <= (state_d == WB_REQ);
      wb_rd_q     <= (state_d == WB_BEAT);
      i_done_q    <= (state_d == DONE) && (owner_d == OWN_I);
      d_done_q    <= (state_d == DONE) && (owner_d == OWN_D);
    end
  end

  // DONE releases the stalls unless a fresh miss is already pending.
  assign busy = (state_q != IDLE) && (state_q != DONE);

  assign mem.o_mem_req_valid = req_valid_q;
  assign mem.o_mem_req_addr  = req_addr_q;
  assign mem.o_mem_req_we    = req_we_q;

  assign o_beat_idx       = cnt;
  assign o_dcache_wb_rd   = wb_rd_q;
  assign o_icache_done    = i_done_q;
  assign o_dcache_done    = d_done_q;
  assign o_icache_fill_we = (state_q == RD_BEAT) && mem.i_mem_beat_valid && (owner_q == OWN_I);
  assign o_dcache_fill_we = (state_q == RD_BEAT) && mem.i_mem_beat_valid && (owner_q == OWN_D);
  assign o_stall_mem      = i_arstn && (i_dcache_miss || busy);
  assign o_stall_fetch    = i_arstn && (i_icache_miss || o_stall_mem);

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Directed bench for mem_refill_ctrl (ADDR 64, DATA 64, 8 beats per line).
module tb_mem_refill_ctrl;

  logic        clk = 1'b0;
  logic        arstn;
  logic        imiss, dmiss, ddirty;
  logic [63:0] iaddr, daddr, wbaddr;
  logic [2:0]  beat_idx;
  logic        ifill, dfill, wbrd, idone, ddone, sfetch, smem;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_refill_ctrl_if #(.ADDR_WIDTH(64)) bus ();

  mem_refill_ctrl #(
    .ADDR_WIDTH  (64),
    .DATA_WIDTH  (64),
    .BLOCK_WORDS (8)
  ) dut (
    .i_clk            (clk),
    .i_arstn          (arstn),
    .i_icache_miss    (imiss),
    .i_icache_addr    (iaddr),
    .i_dcache_miss    (dmiss),
    .i_dcache_addr    (daddr),
    .i_dcache_dirty   (ddirty),
    .i_dcache_wb_addr (wbaddr),
    .mem              (bus),
    .o_beat_idx       (beat_idx),
    .o_icache_fill_we (ifill),
    .o_dcache_fill_we (dfill),
    .o_dcache_wb_rd   (wbrd),
    .o_icache_done    (idone),
    .o_dcache_done    (ddone),
    .o_stall_fetch    (sfetch),
    .o_stall_mem      (smem)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read beats first..7, one beat per cycle; miss dropped after beat drop_at.
  task automatic read_beats(input bit own_d, input int first, input int drop_at);
    for (int i = first; i < 8; i++) begin
      tick();
      chkv("rd_idx", 64'(beat_idx), 64'(i));
      chk1("rd_fill_own", own_d ? dfill : ifill, 1'b1);
      chk1("rd_fill_other", own_d ? ifill : dfill, 1'b0);
      chk1("rd_stall_mem", smem, 1'b1);
      chk1("rd_req_valid", bus.o_mem_req_valid, 1'b0);
      if (i == drop_at) begin
        if (own_d) begin
          dmiss  = 1'b0;
          ddirty = 1'b0;
        end else begin
          imiss = 1'b0;
        end
      end
    end
  endtask

  initial begin
    arstn = 1'b0;
    imiss = 1'b0; dmiss = 1'b0; ddirty = 1'b0;
    iaddr = '0; daddr = '0; wbaddr = '0;
    bus.i_mem_req_ready  = 1'b0;
    bus.i_mem_beat_valid = 1'b0;

    // Reset state
    tick(); tick();
    chk1("rst_req_valid", bus.o_mem_req_valid, 1'b0);
    chkv("rst_req_addr", bus.o_mem_req_addr, 64'h0);
    chk1("rst_we", bus.o_mem_req_we, 1'b0);
    chkv("rst_idx", 64'(beat_idx), 64'h0);
    chk1("rst_wbrd", wbrd, 1'b0);
    chk1("rst_idone", idone, 1'b0);
    chk1("rst_ddone", ddone, 1'b0);
    chk1("rst_sfetch", sfetch, 1'b0);
    chk1("rst_smem", smem, 1'b0);
    arstn = 1'b1;
    tick();

    // Clean I-miss, ready immediate, a beat every cycle
    bus.i_mem_req_ready  = 1'b1;
    bus.i_mem_beat_valid = 1'b1;
    iaddr = 64'h1004;
    imiss = 1'b1;
    #1;
    chk1("i_miss_sfetch", sfetch, 1'b1);
    chk1("i_miss_smem", smem, 1'b0);
    chk1("i_miss_req_valid", bus.o_mem_req_valid, 1'b0);
    tick();
    chk1("i_req_valid", bus.o_mem_req_valid, 1'b1);
    chkv("i_req_addr", bus.o_mem_req_addr, 64'h1000);
    chk1("i_req_we", bus.o_mem_req_we, 1'b0);
    read_beats(1'b0, 0, 7);
    tick();
    chk1("i_done", idone, 1'b1);
    chk1("i_done_d", ddone, 1'b0);
    chk1("i_done_sfetch", sfetch, 1'b0);
    chk1("i_done_req_valid", bus.o_mem_req_valid, 1'b0);
    tick();
    chk1("i_after_done", idone, 1'b0);

    // Dirty D-miss: write-back then refill
    wbaddr = 64'h2040;
    daddr  = 64'h3008;
    ddirty = 1'b1;
    dmiss  = 1'b1;
    #1;
    chk1("d_miss_smem", smem, 1'b1);
    tick();
    chk1("wb_req_valid", bus.o_mem_req_valid, 1'b1);
    chk1("wb_req_we", bus.o_mem_req_we, 1'b1);
    chkv("wb_req_addr", bus.o_mem_req_addr, 64'h2040);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("wb_rd", wbrd, 1'b1);
      chkv("wb_idx", 64'(beat_idx), 64'(i));
      chk1("wb_no_fill", dfill, 1'b0);
    end
    tick();
    chk1("d_rd_req_valid", bus.o_mem_req_valid, 1'b1);
    chk1("d_rd_req_we", bus.o_mem_req_we, 1'b0);
    chkv("d_rd_req_addr", bus.o_mem_req_addr, 64'h3000);
    chk1("d_rd_wbrd_off", wbrd, 1'b0);
    read_beats(1'b1, 0, 7);
    tick();
    chk1("d_done", ddone, 1'b1);
    chk1("d_done_i", idone, 1'b0);
    chk1("d_done_smem", smem, 1'b0);
    tick();

    // Simultaneous D-miss (clean) and I-miss
    daddr = 64'h4010;
    iaddr = 64'h5020;
    dmiss = 1'b1;
    imiss = 1'b1;
    #1;
    chk1("both_smem", smem, 1'b1);
    chk1("both_sfetch", sfetch, 1'b1);
    tick();
    chkv("both_first_addr", bus.o_mem_req_addr, 64'h4000);
    chk1("both_first_we", bus.o_mem_req_we, 1'b0);
    read_beats(1'b1, 0, 7);
    tick();
    chk1("both_d_done", ddone, 1'b1);
    chk1("both_done_smem", smem, 1'b0);
    chk1("both_done_sfetch", sfetch, 1'b1);
    tick();
    chk1("both_idle_req_valid", bus.o_mem_req_valid, 1'b0);
    chk1("both_idle_sfetch", sfetch, 1'b1);
    tick();
    chk1("both_i_req_valid", bus.o_mem_req_valid, 1'b1);
    chkv("both_i_req_addr", bus.o_mem_req_addr, 64'h5000);
    read_beats(1'b0, 0, 7);
    tick();
    chk1("both_i_done", idone, 1'b1);
    tick();

    // Ready withheld 5 cycles, beat_valid toggling 1010...
    bus.i_mem_req_ready  = 1'b0;
    bus.i_mem_beat_valid = 1'b0;
    iaddr = 64'h6038;
    imiss = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk1("hold_req_valid", bus.o_mem_req_valid, 1'b1);
      chkv("hold_req_addr", bus.o_mem_req_addr, 64'h6000);
      if (k < 4) tick();
    end
    bus.i_mem_req_ready = 1'b1;
    tick();
    bus.i_mem_req_ready = 1'b0;
    for (int j = 0; j < 15; j++) begin
      bus.i_mem_beat_valid = (j % 2 == 0);
      #1;
      chkv("tog_idx", 64'(beat_idx), 64'((j + 1) / 2));
      chk1("tog_fill", ifill, (j % 2 == 0));
      chk1("tog_no_done", idone, 1'b0);
      if (j == 14) imiss = 1'b0;
      tick();
    end
    chk1("tog_done", idone, 1'b1);
    bus.i_mem_req_ready  = 1'b1;
    bus.i_mem_beat_valid = 1'b1;
    tick();

    // Reset during RD_BEAT beat 3
    iaddr = 64'h7008;
    imiss = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chkv("pre_rst_idx", 64'(beat_idx), 64'h3);
    chk1("pre_rst_fill", ifill, 1'b1);
    arstn = 1'b0;
    #1;
    chk1("mid_rst_req_valid", bus.o_mem_req_valid, 1'b0);
    chkv("mid_rst_addr", bus.o_mem_req_addr, 64'h0);
    chkv("mid_rst_idx", 64'(beat_idx), 64'h0);
    chk1("mid_rst_fill", ifill, 1'b0);
    chk1("mid_rst_sfetch", sfetch, 1'b0);
    chk1("mid_rst_smem", smem, 1'b0);
    tick();
    arstn = 1'b1;
    tick();
    chk1("post_rst_req_valid", bus.o_mem_req_valid, 1'b1);
    chkv("post_rst_req_addr", bus.o_mem_req_addr, 64'h7000);
    read_beats(1'b0, 0, 7);
    tick();
    chk1("post_rst_done", idone, 1'b1);
    tick();

    // Miss dropped mid-transfer
    iaddr = 64'h8030;
    imiss = 1'b1;
    tick();
    chkv("drop_req_addr", bus.o_mem_req_addr, 64'h8000);
    read_beats(1'b0, 0, 2);
    tick();
    chk1("drop_done", idone, 1'b1);
    tick();
    chk1("drop_idle_req", bus.o_mem_req_valid, 1'b0);
    tick();
    chk1("drop_no_req", bus.o_mem_req_valid, 1'b0);
    chk1("drop_no_stall", sfetch, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
